// File: rtl/regbank_arbiter.sv
// regbank_arbiter
//   Round-robin arbiter and sequencer for a bank of 8 single-bit-style
//   registers that share a D input and a tri-state Q bus. One read or write
//   is in flight at a time. Every output is driven from a flop, so the bank
//   control lines never glitch on requester inputs.
//
// Ports
//   Clock           system clock, rising edge
//   Reset           synchronous active-high reset
//   Tick            global advance; the FSM only moves on edges with Tick=1
//   Req/ReqWrite    per-requester request level and direction (1 = write)
//   ReqAddr         3-bit register index per requester, packed
//   ReqData         write data per requester, packed
//   BusQ            shared register output bus
//   Grant           one-hot owner, held through ACCESS and DONE
//   Done            completion pulse to the owner (held while stalled)
//   RdData          last value read from the bus
//   RegD            common D to all registers
//   RegClockEnable  per-register write enable, at most one high
//   RegCs           per-register deselect (1 = high-Z), at most one low
module regbank_arbiter #(
    parameter int NrOfRequesters = 4,
    parameter int NrOfBits       = 8
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic                               Tick,
    input  logic [NrOfRequesters-1:0]          Req,
    input  logic [NrOfRequesters-1:0]          ReqWrite,
    input  logic [3*NrOfRequesters-1:0]        ReqAddr,
    input  logic [NrOfBits*NrOfRequesters-1:0] ReqData,
    input  logic [NrOfBits-1:0]                BusQ,
    output logic [NrOfRequesters-1:0]          Grant,
    output logic [NrOfRequesters-1:0]          Done,
    output logic [NrOfBits-1:0]                RdData,
    output logic [NrOfBits-1:0]                RegD,
    output logic [7:0]                         RegClockEnable,
    output logic [7:0]                         RegCs
);

    localparam int PtrW = $clog2(NrOfRequesters);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Unpacked views of the flattened request buses.
    logic [NrOfRequesters-1:0][2:0]          req_addr;
    logic [NrOfRequesters-1:0][NrOfBits-1:0] req_data;

    for (genvar g = 0; g < NrOfRequesters; g++) begin : g_unpack
        assign req_addr[g] = ReqAddr[3*g +: 3];
        assign req_data[g] = ReqData[NrOfBits*g +: NrOfBits];
    end

    state_t                    state_q, state_n;
    logic [PtrW-1:0]           ptr_q, ptr_n;
    logic [PtrW-1:0]           win_q, win_n;
    logic                      wr_q, wr_n;
    logic [2:0]                addr_q, addr_n;
    logic [NrOfRequesters-1:0] grant_n, done_n;
    logic [NrOfBits-1:0]       rddata_n, regd_n;
    logic [7:0]                ce_n, cs_n;

    // Round-robin pick: first set Req at ptr, ptr+1, ... wrapping at
    // NrOfRequesters (which need not be a power of two).
    logic            any_req;
    logic [PtrW-1:0] pick;

    always_comb begin
        logic [PtrW-1:0] cand;
        any_req = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int k = 0; k < NrOfRequesters; k++) begin
            cand = PtrW'((int'(ptr_q) + k) % NrOfRequesters);
            if (!any_req && Req[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            win_q          <= '0;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            Grant          <= '0;
            Done           <= '0;
            RdData         <= '0;
            RegD           <= '0;
            RegClockEnable <= '0;
            RegCs          <= 8'hFF;
        end else begin
            state_q        <= state_n;
            ptr_q          <= ptr_n;
            win_q          <= win_n;
            wr_q           <= wr_n;
            addr_q         <= addr_n;
            Grant          <= grant_n;
            Done           <= done_n;
            RdData         <= rddata_n;
            RegD           <= regd_n;
            RegClockEnable <= ce_n;
            RegCs          <= cs_n;
        end
    end

    // Next-state and next-output logic. Outputs are computed one state
    // ahead so they land in flops together with the state they belong to.
    always_comb begin
        state_n  = state_q;
        ptr_n    = ptr_q;
        win_n    = win_q;
        wr_n     = wr_q;
        addr_n   = addr_q;
        grant_n  = Grant;
        done_n   = Done;
        rddata_n = RdData;
        regd_n   = RegD;
        ce_n     = RegClockEnable;
        cs_n     = RegCs;

        if (Tick) begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_n       = ACCESS;
                        win_n         = pick;
                        wr_n          = ReqWrite[pick];
                        addr_n        = req_addr[pick];
                        grant_n       = '0;
                        grant_n[pick] = 1'b1;
                        ce_n          = '0;
                        cs_n          = 8'hFF;
                        if (ReqWrite[pick]) begin
                            regd_n                 = req_data[pick];
                            ce_n[req_addr[pick]]   = 1'b1;
                        end else begin
                            cs_n[req_addr[pick]]   = 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    // The register captures RegD on this same edge for a
                    // write; for a read the selected register is on BusQ.
                    state_n        = DONE;
                    done_n         = '0;
                    done_n[win_q]  = 1'b1;
                    ce_n           = '0;
                    cs_n           = 8'hFF;
                    if (!wr_q) rddata_n = BusQ;
                end
                DONE: begin
                    state_n = IDLE;
                    ptr_n   = (win_q == PtrW'(NrOfRequesters - 1)) ? '0 : win_q + 1'b1;
                    grant_n = '0;
                    done_n  = '0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_arbiter.sv
module tb_regbank_arbiter;

    logic        Clock = 1'b0;
    logic        Reset, Tick;
    logic [3:0]  Req, ReqWrite;
    logic [11:0] ReqAddr;
    logic [31:0] ReqData;
    logic [7:0]  BusQ;
    logic [3:0]  Grant, Done;
    logic [7:0]  RdData, RegD, RegClockEnable, RegCs;

    regbank_arbiter #(.NrOfRequesters(4), .NrOfBits(8)) dut (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .Req(Req), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqData(ReqData), .BusQ(BusQ), .Grant(Grant), .Done(Done),
        .RdData(RdData), .RegD(RegD), .RegClockEnable(RegClockEnable), .RegCs(RegCs)
    );

    always #5 Clock = ~Clock;

    // Register bank model: capture on CE && Tick, drive bus when cs low.
    logic [7:0] bank [8];
    always @(posedge Clock)
        for (int i = 0; i < 8; i++)
            if (RegClockEnable[i] && Tick) bank[i] <= RegD;

    always_comb begin
        BusQ = 8'h00;
        for (int i = 0; i < 8; i++)
            if (!RegCs[i]) BusQ = bank[i];
    end

    typedef struct {
        logic [3:0] grant;
        bit         rd;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   sb_en = 1'b1;
    logic [3:0] done_prev = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: pops one expectation per completion pulse.
    always @(negedge Clock) begin
        if (!Reset && sb_en && Done != 4'b0 && done_prev == 4'b0) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_done", {28'b0, Done}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_done", {28'b0, Done}, {28'b0, e.grant});
                chk("sb_grant", {28'b0, Grant}, {28'b0, e.grant});
                if (e.rd) chk("sb_rddata", {24'b0, RdData}, {24'b0, e.data});
            end
        end
        done_prev = Done;
    end

    // Bus invariants, every cycle including reset.
    always @(negedge Clock) begin
        logic ok;
        ok = ($countones(~RegCs) <= 1) && ($countones(RegClockEnable) <= 1) &&
             !((RegCs != 8'hFF) && (RegClockEnable != 8'h00));
        chk("bus_excl", {31'b0, ok}, 32'h1);
    end

    task automatic do_tx(input logic [3:0] mask, input int w, input bit wr,
                         input logic [2:0] a, input logic [7:0] d, input logic [7:0] rexp);
        exp_t e;
        logic [7:0] onehot;
        onehot  = 8'h01 << a;
        e.grant = 4'b0001 << w;
        e.rd    = !wr;
        e.data  = rexp;
        exp_q.push_back(e);
        Req      = mask;
        ReqWrite = {4{wr}};
        ReqAddr  = {4{a}};
        ReqData  = {4{d}};
        @(posedge Clock); @(negedge Clock);
        chk("tx_grant", {28'b0, Grant}, {28'b0, e.grant});
        if (wr) begin
            chk("tx_ce", {24'b0, RegClockEnable}, {24'b0, onehot});
            chk("tx_regd", {24'b0, RegD}, {24'b0, d});
        end else begin
            chk("tx_cs", {24'b0, RegCs}, {24'b0, ~onehot});
        end
        Req = '0;
        @(posedge Clock); @(negedge Clock);
        chk("tx_cs_done", {24'b0, RegCs}, 32'hFF);
        chk("tx_ce_done", {24'b0, RegClockEnable}, 32'h0);
        @(posedge Clock); @(negedge Clock);
        chk("tx_grant_idle", {28'b0, Grant}, 32'h0);
    endtask

    initial begin
        logic [7:0] pre;
        Reset = 1'b1; Tick = 1'b1; Req = '0; ReqWrite = '0; ReqAddr = '0; ReqData = '0;
        for (int i = 0; i < 8; i++) bank[i] = 8'h00;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("rst_grant", {28'b0, Grant}, 32'h0);
        chk("rst_done", {28'b0, Done}, 32'h0);
        chk("rst_rddata", {24'b0, RdData}, 32'h0);
        chk("rst_regd", {24'b0, RegD}, 32'h0);
        chk("rst_ce", {24'b0, RegClockEnable}, 32'h0);
        chk("rst_cs", {24'b0, RegCs}, 32'hFF);
        Reset = 1'b0;

        // Single write then read back (ptr 0 -> 2 -> 3).
        do_tx(4'b0010, 1, 1'b1, 3'd5, 8'hA5, 8'h00);
        chk("bank5", {24'b0, bank[5]}, 32'hA5);
        do_tx(4'b0100, 2, 1'b0, 3'd5, 8'h00, 8'hA5);
        chk("rddata_hold", {24'b0, RdData}, 32'hA5);

        // Tick stall in ACCESS and in DONE (requester 3, ptr -> 0).
        pre = bank[3];
        begin
            exp_t e;
            e.grant = 4'b1000; e.rd = 1'b0; e.data = 8'h00;
            exp_q.push_back(e);
        end
        Req = 4'b1000; ReqWrite = 4'b1111; ReqAddr = {4{3'd3}}; ReqData = {4{8'h3C}};
        @(posedge Clock); @(negedge Clock);
        chk("stall_grant", {28'b0, Grant}, 32'h8);
        Tick = 1'b0; Req = '0;
        for (int c = 0; c < 4; c++) begin
            @(posedge Clock); @(negedge Clock);
            chk("stall_ce", {24'b0, RegClockEnable}, 32'h08);
            chk("stall_done", {28'b0, Done}, 32'h0);
            chk("stall_nocap", {24'b0, bank[3]}, {24'b0, pre});
        end
        Tick = 1'b1;
        @(posedge Clock); @(negedge Clock);
        chk("stall_cap", {24'b0, bank[3]}, 32'h3C);
        Tick = 1'b0;
        repeat (2) begin
            @(posedge Clock); @(negedge Clock);
            chk("stall_done_hold", {28'b0, Done}, 32'h8);
        end
        Tick = 1'b1;
        @(posedge Clock); @(negedge Clock);
        chk("stall_idle", {28'b0, Grant}, 32'h0);

        // Fairness with all four requesting: 0,1,2,3,0 at edges 0,3,6,9,12.
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            e.grant = 4'b0001 << (i % 4); e.rd = 1'b0; e.data = 8'h00;
            exp_q.push_back(e);
        end
        Req = 4'b1111; ReqWrite = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            ReqAddr[3*i +: 3] = 3'(4 + i);
            ReqData[8*i +: 8] = 8'h10 + 8'(i);
        end
        for (int t = 0; t <= 12; t++) begin
            @(posedge Clock); @(negedge Clock);
            if (t % 3 == 0) chk("fair_grant", {28'b0, Grant}, 32'h1 << ((t / 3) % 4));
        end
        Req = '0;
        repeat (2) begin @(posedge Clock); @(negedge Clock); end
        chk("fair_bank6", {24'b0, bank[6]}, 32'h12);

        // Reset during a write ACCESS (ptr 1 -> 3 after the first write).
        do_tx(4'b0100, 2, 1'b1, 3'd2, 8'h77, 8'h00);
        Req = 4'b0100; ReqWrite = 4'b1111; ReqAddr = {4{3'd2}}; ReqData = {4{8'h99}};
        @(posedge Clock); @(negedge Clock);
        chk("rstmid_grant", {28'b0, Grant}, 32'h4);
        Tick = 1'b0; Reset = 1'b1; Req = '0;
        @(posedge Clock); @(negedge Clock);
        chk("rstmid_grant0", {28'b0, Grant}, 32'h0);
        chk("rstmid_ce", {24'b0, RegClockEnable}, 32'h0);
        chk("rstmid_cs", {24'b0, RegCs}, 32'hFF);
        chk("rstmid_bank2", {24'b0, bank[2]}, 32'h77);
        Reset = 1'b0; Tick = 1'b1;
        // ptr back at 0 picks requester 0 over 3.
        do_tx(4'b1001, 0, 1'b0, 3'd2, 8'h00, 8'h77);

        // Random traffic; only the bus invariants are checked here.
        sb_en = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            Req      = 4'($urandom);
            ReqWrite = 4'($urandom);
            ReqAddr  = 12'($urandom);
            ReqData  = $urandom;
            Tick     = 1'($urandom);
            @(posedge Clock); @(negedge Clock);
        end
        Req = '0; Tick = 1'b1;
        repeat (4) begin @(posedge Clock); @(negedge Clock); end
        chk("drain_idle", {28'b0, Grant}, 32'h0);
        sb_en = 1'b1;

        chk("sb_empty", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
